spi_reg_bridge: RTL and testbench

//  Byte-protocol layer downstream of the SPI slave byte engine. Consumes the

---
 rtl/spi_reg_bridge.sv | 164 ++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns the received byte stream of one SPI frame into
// single-cycle register file accesses. A frame (SS low) starts with a
// command byte {rw, addr}. Write frames then carry data bytes for addr,
// addr+1, ... Read frames carry a turnaround byte (the slave returns status)
// followed by bytes whose transmit slots return reg[addr], reg[addr+1], ...
// Raising SS ends the frame at any point. An unfinished byte is dropped.
module spi_reg_bridge #(
  parameter int ADDR_W   = 7,    // 1..7, taken from the low bits of the cmd byte
  parameter bit AUTO_INC = 1'b1  // 1: advance the address after every data byte
) (
  input  logic              clk,
  input  logic              rst,        // synchronous, active low
  input  logic              ss,         // raw slave select, active low
  input  logic              rx_done,    // one-cycle strobe per received byte
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,    // byte the engine loads for the next slot
  input  logic [7:0]        status,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,  // valid the cycle after reg_re
  output logic              frame_act
);

  // Address arithmetic wraps naturally at ADDR_W bits.
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(AUTO_INC);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_TURN,
    RD
  } state_t;

  state_t state, state_next;

  logic ss_m;        // first synchronizer stage
  logic ss_s;        // synchronized slave select
  logic rdata_pend;  // reg_rdata carries the data of last cycle's read
  logic ld_cmd;      // capture the address from the command byte
  logic ld_wdata;    // capture a data byte and issue a write
  logic issue_re;    // issue a read strobe next cycle
  logic adv_rd;      // step the address before a follow-on read

  // Bring the asynchronous SS pin into the clk domain. The flops reset to the
  // deasserted level so a reset never fakes the start of a frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ss_m <= 1'b1;
      ss_s <= 1'b1;
    end else begin
      // NOTE: sequential state is always assigned with <= so that every flop
      // samples the values from before the edge, whatever the statement order.
      ss_m <= ss;
      ss_s <= ss_m;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-byte control decisions. SS deasserted wins over
  // everything, including a byte strobe arriving in the same cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_next = state;
    ld_cmd     = 1'b0;
    ld_wdata   = 1'b0;
    issue_re   = 1'b0;
    adv_rd     = 1'b0;

    if (ss_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = CMD;
        end
        CMD: begin
          if (rx_done) begin
            ld_cmd = 1'b1;
            if (rx_data[7]) begin
              issue_re   = 1'b1;
              state_next = RD_TURN;
            end else begin
              state_next = WR;
            end
          end
        end
        WR: begin
          if (rx_done) begin
            ld_wdata = 1'b1;
          end
        end
        RD_TURN: begin
          // The turnaround byte itself is discarded; it only paces the read.
          if (rx_done) begin
            adv_rd     = 1'b1;
            issue_re   = 1'b1;
            state_next = RD;
          end
        end
        RD: begin
          if (rx_done) begin
            adv_rd   = 1'b1;
            issue_re = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Register bus and transmit byte. All updates land in the cycles right
  // after a byte strobe, long before the engine loads the next transmit byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_data    <= 8'h00;
      reg_addr   <= '0;
      reg_wdata  <= 8'h00;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      rdata_pend <= 1'b0;
    end else begin
      reg_we     <= ld_wdata;
      reg_re     <= issue_re;
      rdata_pend <= reg_re;

      if (ld_wdata) begin
        reg_wdata <= rx_data;
      end

      // Writes use the current address and step it once the strobe is done;
      // reads step it together with issuing the next strobe.
      if (ld_cmd) begin
        reg_addr <= rx_data[ADDR_W-1:0];
      end else if (adv_rd || reg_we) begin
        reg_addr <= reg_addr + ADDR_STEP;
      end

      // Command and turnaround slots return status. Read data slots return
      // the register value once it comes back. Write slots keep the last byte.
      if (state == IDLE || state == CMD) begin
        tx_data <= status;
      end else if (rdata_pend) begin
        tx_data <= reg_rdata;
      end
    end
  end

  assign frame_act = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge. Two instances share one stimulus stream:
// u_a (ADDR_W=7, AUTO_INC=1) and u_b (ADDR_W=5, AUTO_INC=0). Frames are
// driven at byte level. Each instance's register bus activity and the
// transmit bytes it offers are compared against a frame-level model.
module tb_spi_reg_bridge;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct packed {
    logic [4:0][7:0] b;       // frame bytes, b[0] = command
    int              n;       // bytes in the frame
    int              mode;    // 0 normal, 1 last strobe meets SS rise, 2 last byte cut short
    int              we_a;
    int              re_a;
    int              last_a;  // address of the last access, -1 if none
    logic [7:0]      miso_a;  // last transmit byte offered by u_a
    int              we_b;
    int              re_b;
    int              last_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] status = 8'h00;

  logic [7:0] tx_a, wdata_a, rdata_a;
  logic [6:0] addr_a;
  logic       we_a, re_a, act_a_o;
  logic [7:0] tx_b, wdata_b, rdata_b;
  logic [4:0] addr_b;
  logic       we_b, re_b, act_b_o;

  logic [7:0] mem_a [128];
  logic [7:0] mem_b [32];
  logic [7:0] mm_a [128];
  logic [7:0] mm_b [32];

  acc_t act_a[$];
  acc_t act_b[$];
  int   bad_a = 0;
  int   bad_b = 0;
  logic pwe_a = 1'b0, pre_a = 1'b0, pwe_b = 1'b0, pre_b = 1'b0;

  int         n_checks = 0;
  int         n_err = 0;
  int         start_a, start_b;
  logic [7:0] last_miso_a, last_miso_b;
  vec_t       vecs[$];
  vec_t       v;

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADDR_W(7), .AUTO_INC(1'b1)) u_a (
    .clk(clk), .rst(rst), .ss(ss), .rx_done(rx_done), .rx_data(rx_data),
    .tx_data(tx_a), .status(status), .reg_addr(addr_a), .reg_wdata(wdata_a),
    .reg_we(we_a), .reg_re(re_a), .reg_rdata(rdata_a), .frame_act(act_a_o)
  );

  spi_reg_bridge #(.ADDR_W(5), .AUTO_INC(1'b0)) u_b (
    .clk(clk), .rst(rst), .ss(ss), .rx_done(rx_done), .rx_data(rx_data),
    .tx_data(tx_b), .status(status), .reg_addr(addr_b), .reg_wdata(wdata_b),
    .reg_we(we_b), .reg_re(re_b), .reg_rdata(rdata_b), .frame_act(act_b_o)
  );

  // Register files seen by the two instances: write on reg_we, read data
  // returned one cycle after reg_re. Cleared while reset is held.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) mem_a[i] <= 8'h00;
      for (int i = 0; i < 32; i++) mem_b[i] <= 8'h00;
      rdata_a <= 8'h00;
      rdata_b <= 8'h00;
    end else begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      if (re_a) rdata_a <= mem_a[addr_a];
      if (we_b) mem_b[addr_b] <= wdata_b;
      if (re_b) rdata_b <= mem_b[addr_b];
    end
  end

  // Log every bus strobe and count overlapping or stretched strobes.
  always @(negedge clk) begin
    if (rst) begin
      if (we_a) act_a.push_back(acc_t'({1'b1, 8'(addr_a), wdata_a}));
      if (re_a) act_a.push_back(acc_t'({1'b0, 8'(addr_a), 8'h00}));
      if (we_b) act_b.push_back(acc_t'({1'b1, 8'(addr_b), wdata_b}));
      if (re_b) act_b.push_back(acc_t'({1'b0, 8'(addr_b), 8'h00}));
      if ((we_a && re_a) || (we_a && pwe_a) || (re_a && pre_a)) bad_a++;
      if ((we_b && re_b) || (we_b && pwe_b) || (re_b && pre_b)) bad_b++;
    end
    pwe_a = we_a;
    pre_a = re_a;
    pwe_b = we_b;
    pre_b = re_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] mm_rd(input int d, input int a);
    if (d == 0) return mm_a[a];
    return mm_b[a];
  endfunction

  task automatic mm_wr(input int d, input int a, input logic [7:0] val);
    if (d == 0) mm_a[a] = val;
    else mm_b[a] = val;
  endtask

  // Frame-level reference: the accesses a frame of ns accepted bytes must
  // cause, and the transmit bytes offered at frame start and at each byte end.
  task automatic model_frame(input int d, input logic [4:0][7:0] b, input int ns,
                             input logic [7:0] st, output acc_t eq[$],
                             output logic [7:0] em[$]);
    int aw, inc, mask, base, a;
    aw   = (d == 0) ? 7 : 5;
    inc  = (d == 0) ? 1 : 0;
    mask = (1 << aw) - 1;
    base = int'(b[0]) & mask;
    eq.delete();
    em.delete();
    em.push_back(st);
    if (ns >= 1) em.push_back(st);
    if (!b[0][7]) begin
      for (int k = 1; k < ns; k++) begin
        a = (base + (k - 1) * inc) & mask;
        eq.push_back(acc_t'({1'b1, 8'(a), b[k]}));
        mm_wr(d, a, b[k]);
        em.push_back(st);
      end
    end else begin
      for (int k = 0; k < ns; k++) begin
        a = (base + k * inc) & mask;
        eq.push_back(acc_t'({1'b0, 8'(a), 8'h00}));
      end
      for (int k = 1; k < ns; k++) begin
        em.push_back(mm_rd(d, (base + (k - 1) * inc) & mask));
      end
    end
  endtask

  task automatic cmp_acc(input string tag, input acc_t exp[$], input acc_t got[$], input int start);
    check({tag, " access count"}, got.size() - start, exp.size());
    for (int i = 0; i < exp.size() && start + i < got.size(); i++)
      check({tag, " access"}, got[start + i], exp[i]);
  endtask

  task automatic cmp_bytes(input string tag, input logic [7:0] exp[$], input logic [7:0] got[$]);
    check({tag, " miso count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check({tag, " miso byte"}, got[i], exp[i]);
  endtask

  // Drive one frame byte by byte and compare both instances with the model.
  task automatic do_frame(input string tag, input logic [4:0][7:0] b, input int n,
                          input int mode, input logic [7:0] st);
    int         ns;
    acc_t       ea[$];
    acc_t       eb[$];
    logic [7:0] ma[$];
    logic [7:0] mb[$];
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    ns = (mode == 0) ? n : n - 1;
    model_frame(0, b, ns, st, ea, ma);
    model_frame(1, b, ns, st, eb, mb);
    start_a = act_a.size();
    start_b = act_b.size();
    status = st;
    repeat (3) tick();
    ss = 1'b0;
    repeat (6) tick();
    got_a.push_back(tx_a);
    got_b.push_back(tx_b);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && mode == 2) begin
        repeat (8) tick();
      end else if (i == n - 1 && mode == 1) begin
        // SS rises so that the synchronized level is high exactly when the
        // final strobe arrives; that strobe must be ignored.
        repeat (10) tick();
        ss = 1'b1;
        tick();
        tick();
        rx_data = b[i];
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        check({tag, " abort we_a"}, we_a, 1'b0);
        check({tag, " abort re_a"}, re_a, 1'b0);
        check({tag, " abort we_b"}, we_b, 1'b0);
        check({tag, " abort re_b"}, re_b, 1'b0);
      end else begin
        repeat (10) tick();
        got_a.push_back(tx_a);
        got_b.push_back(tx_b);
        rx_data = b[i];
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        check({tag, " we_a latency"}, we_a, (!b[0][7] && i > 0));
        check({tag, " re_a latency"}, re_a, b[0][7]);
        check({tag, " we_b latency"}, we_b, (!b[0][7] && i > 0));
        check({tag, " re_b latency"}, re_b, b[0][7]);
      end
    end
    repeat (6) tick();
    ss = 1'b1;
    repeat (6) tick();
    cmp_acc({tag, "/a"}, ea, act_a, start_a);
    cmp_acc({tag, "/b"}, eb, act_b, start_b);
    cmp_bytes({tag, "/a"}, ma, got_a);
    cmp_bytes({tag, "/b"}, mb, got_b);
    last_miso_a = got_a[got_a.size() - 1];
    last_miso_b = got_b[got_b.size() - 1];
  endtask

  task automatic add_vec(input logic [7:0] b0, b1, b2, b3, b4, input int n, mode,
                         input int we_a_e, re_a_e, last_a_e, input logic [7:0] miso_a_e,
                         input int we_b_e, re_b_e, last_b_e);
    vec_t r;
    r.b[0] = b0; r.b[1] = b1; r.b[2] = b2; r.b[3] = b3; r.b[4] = b4;
    r.n = n; r.mode = mode;
    r.we_a = we_a_e; r.re_a = re_a_e; r.last_a = last_a_e; r.miso_a = miso_a_e;
    r.we_b = we_b_e; r.re_b = re_b_e; r.last_b = last_b_e;
    vecs.push_back(r);
  endtask

  task automatic count_log(input acc_t q[$], input int start, output int nw, output int nr);
    nw = 0;
    nr = 0;
    for (int i = start; i < q.size(); i++) begin
      if (q[i].wr) nw++;
      else nr++;
    end
  endtask

  task automatic check_last(input string tag, input acc_t q[$], input int start, input int exp);
    if (exp >= 0) begin
      if (q.size() > start) check(tag, q[q.size() - 1].addr, exp);
      else check(tag, 32'hFFFF_FFFF, exp);
    end
  endtask

  initial begin
    int nw, nr;
    logic [4:0][7:0] rb;
    for (int i = 0; i < 128; i++) mm_a[i] = 8'h00;
    for (int i = 0; i < 32; i++) mm_b[i] = 8'h00;

    //      bytes                                n  md  we re last  miso   we re last
    add_vec(8'h05, 8'h11, 8'h22, 8'h33, 8'h00, 4, 0, 3, 0, 'h07, 8'h5A, 3, 0, 'h05);
    add_vec(8'h10, 8'hA1, 8'hB2, 8'hC3, 8'h00, 4, 0, 3, 0, 'h12, 8'h5A, 3, 0, 'h10);
    add_vec(8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 5, 1, 0, 4, 'h13, 8'hC3, 0, 4, 'h10);
    add_vec(8'h7F, 8'hAA, 8'hBB, 8'h00, 8'h00, 3, 0, 2, 0, 'h00, 8'h5A, 2, 0, 'h1F);
    add_vec(8'h03, 8'h01, 8'h02, 8'h00, 8'h00, 3, 0, 2, 0, 'h04, 8'h5A, 2, 0, 'h03);
    add_vec(8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 3, 0, 0, 3, 'h05, 8'h02, 0, 3, 'h03);
    add_vec(8'h20, 8'h55, 8'h99, 8'h00, 8'h00, 3, 2, 1, 0, 'h20, 8'h5A, 1, 0, 'h00);
    add_vec(8'h21, 8'h66, 8'h00, 8'h00, 8'h00, 2, 0, 1, 0, 'h21, 8'h5A, 1, 0, 'h01);
    add_vec(8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 'h05, 8'h5A, 0, 1, 'h05);
    add_vec(8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, -1, 8'h5A, 0, 0, -1);

    // Reset values: tx_data is zero, not status.
    status = 8'h5A;
    repeat (3) tick();
    check("reset tx_a", tx_a, 8'h00);
    check("reset addr_a", addr_a, 7'h00);
    check("reset wdata_a", wdata_a, 8'h00);
    check("reset we_a", we_a, 1'b0);
    check("reset re_a", re_a, 1'b0);
    check("reset frame_act_a", act_a_o, 1'b0);
    check("reset tx_b", tx_b, 8'h00);
    rst = 1'b1;
    tick();
    check("idle tx follows status", tx_a, 8'h5A);

    // Frame start: two synchronizer stages, then the state leaves IDLE.
    ss = 1'b0;
    tick();
    tick();
    check("frame_act before sync", act_a_o, 1'b0);
    tick();
    check("frame_act after sync", act_a_o, 1'b1);

    // Reset arriving together with a data byte of a write frame.
    repeat (4) tick();
    rx_data = 8'h05;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat (8) tick();
    rx_data = 8'h11;
    rx_done = 1'b1;
    rst = 1'b0;
    tick();
    rx_done = 1'b0;
    check("midreset we_a", we_a, 1'b0);
    check("midreset addr_a", addr_a, 7'h00);
    check("midreset wdata_a", wdata_a, 8'h00);
    check("midreset tx_a", tx_a, 8'h00);
    check("midreset frame_act_a", act_a_o, 1'b0);
    rst = 1'b1;
    tick();
    check("post reset we_a", we_a, 1'b0);
    check("post reset frame_act_a", act_a_o, 1'b0);
    ss = 1'b1;
    repeat (5) tick();
    check("no access across reset a", act_a.size(), 0);
    check("no access across reset b", act_b.size(), 0);

    // Frame end: frame_act drops on the third edge that sees SS high.
    ss = 1'b0;
    repeat (6) tick();
    check("frame_act in frame", act_a_o, 1'b1);
    ss = 1'b1;
    tick();
    tick();
    check("frame_act 2 edges after ss", act_a_o, 1'b1);
    tick();
    check("frame_act 3 edges after ss", act_a_o, 1'b0);
    repeat (3) tick();

    // Directed frames.
    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      do_frame($sformatf("row%0d", r), v.b, v.n, v.mode, 8'h5A);
      count_log(act_a, start_a, nw, nr);
      check($sformatf("row%0d we count a", r), nw, v.we_a);
      check($sformatf("row%0d re count a", r), nr, v.re_a);
      check_last($sformatf("row%0d last addr a", r), act_a, start_a, v.last_a);
      check($sformatf("row%0d last miso a", r), last_miso_a, v.miso_a);
      count_log(act_b, start_b, nw, nr);
      check($sformatf("row%0d we count b", r), nw, v.we_b);
      check($sformatf("row%0d re count b", r), nr, v.re_b);
      check_last($sformatf("row%0d last addr b", r), act_b, start_b, v.last_b);
    end

    // Random frames against the model.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 5; k++) rb[k] = 8'($urandom);
      do_frame($sformatf("rnd%0d", f), rb, int'($urandom_range(1, 5)),
               int'($urandom_range(0, 2)), 8'($urandom));
    end

    check("strobe overlap/width a", bad_a, 0);
    check("strobe overlap/width b", bad_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
